// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
package fifo_arb_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      STALL = 2'd2
   } arb_state_e;

   // Returns {found, idx}: rotate req right by ptr, take the lowest set bit, rotate the index back.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      logic [15:0] dbl;
      logic [7:0]  rot;
      logic [3:0]  res;
      int          sum;
      dbl = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            dbl[i]     = req[i];
            dbl[i + n] = req[i];
         end
      end
      rot = 8'(dbl >> ptr);
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         if (k < n && rot[k]) begin
            sum = k + int'(ptr);
            if (sum >= n) sum = sum - n;
            res = {1'b1, 3'(sum)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, modulo NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [7:0] req_ext;
   logic [3:0] pick;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req_i;
   end

   assign pick    = rr_pick(req_ext, 3'(rr_ptr_i), NUM_REQ);
   assign found_o = pick[3];
   assign idx_o   = IDX_W'(pick[2:0]);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin sharing of the async FIFO write port; optional per-grant bursts under FIFO_ARB_BURST_EN.
// Grant latency 1 clk, then 1 beat/clk; stalls on full and resumes only once almost_full clears.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = fifo_arb_pkg::DATA_W_DEF,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic                      clk_write,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         fifo_data_in,
   output logic                      fifo_write_enable,
   input  logic                      fifo_full,
   input  logic                      fifo_almost_full,
   output logic                      busy,
   output logic [CNT_W-1:0]          wr_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
      $error("fifo_write_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
   end

   arb_state_e         state_q, state_d;
   logic               grant_vld_q, grant_vld_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               new_grant;
   logic               burst_hold;
   logic [DATA_W-1:0]  beat [NUM_REQ];

   rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .req_i    (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
      assign beat[g] = req_data[g*DATA_W +: DATA_W];
   end

   // rst gates ready so an in-flight beat is never written in the reset cycle.
   always_comb begin
      req_ready = '0;
      if (grant_vld_q && state_q == GRANT && !fifo_full && !rst)
         req_ready[grant_idx_q] = 1'b1;
   end

   assign fifo_write_enable = |(req_valid & req_ready);
   assign fifo_data_in      = fifo_write_enable ? beat[grant_idx_q] : '0;
   assign busy              = !rst && (state_q != IDLE);
   assign wr_count          = rst ? '0 : wr_count_q;

`ifdef FIFO_ARB_BURST_EN
   localparam int BC_W = $clog2(MAX_BURST) + 1;
   logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;

   assign burst_hold = fifo_write_enable && (beat_cnt_q < BC_W'(MAX_BURST - 1));

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (new_grant)              beat_cnt_d = '0;
      else if (fifo_write_enable) beat_cnt_d = beat_cnt_q + BC_W'(1);
   end

   always_ff @(posedge clk_write) begin
      if (rst) beat_cnt_q <= '0;
      else     beat_cnt_q <= beat_cnt_d;
   end
`else
   assign burst_hold = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_vld_d = grant_vld_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      new_grant   = 1'b0;
      wr_count_d  = fifo_write_enable ? wr_count_q + CNT_W'(1) : wr_count_q;
      case (state_q)
         IDLE: begin
            if (pick_found) new_grant = 1'b1;
         end
         GRANT: begin
            if (fifo_full) begin
               state_d = STALL;
            end else if (burst_hold) begin
               state_d = GRANT;
            end else if (pick_found) begin
               new_grant = 1'b1;
            end else begin
               state_d     = IDLE;
               grant_vld_d = 1'b0;
            end
         end
         STALL: begin
            if (!fifo_almost_full) state_d = GRANT;
         end
         default: begin
            state_d     = IDLE;
            grant_vld_d = 1'b0;
         end
      endcase
      // Advancing past the winner makes it lowest priority at the next arbitration.
      if (new_grant) begin
         state_d     = GRANT;
         grant_vld_d = 1'b1;
         grant_idx_d = pick_idx;
         rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_write) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_vld_q <= 1'b0;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_vld_q <= grant_vld_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_count_q  <= wr_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter plus reset, burst-order and counter-wrap sequences.
module tb_fifo_write_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  fifo_data_in;
   logic        fifo_write_enable;
   logic        fifo_full;
   logic        fifo_almost_full;
   logic        busy;
   logic [15:0] wr_count;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4), .CNT_W(16)) dut (
      .clk_write         (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_data          (req_data),
      .req_ready         (req_ready),
      .fifo_data_in      (fifo_data_in),
      .fifo_write_enable (fifo_write_enable),
      .fifo_full         (fifo_full),
      .fifo_almost_full  (fifo_almost_full),
      .busy              (busy),
      .wr_count          (wr_count)
   );

   typedef struct {
      logic [3:0]  valid;
      logic        full;
      logic        afull;
      logic [3:0]  ready;
      logic        we;
      logic [7:0]  data;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [18];
   int   exp_order [12];

   function automatic vec_t mk(logic [3:0] v, logic f, logic af, logic [3:0] r, logic w,
                               logic [7:0] d, logic b, logic [15:0] c);
      vec_t t;
      t.valid = v; t.full = f; t.afull = af; t.ready = r;
      t.we = w; t.data = d; t.busy = b; t.cnt = c;
      return t;
   endfunction

   function automatic int oh2idx(logic [3:0] r);
      case (r)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {2'b00, req_ready, fifo_write_enable, fifo_data_in, busy, wr_count};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int k;
      int writes;
      bit seen_ffff;

      // Requester data: r0=11 r1=22 r2=A5 r3=44
      req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      rst = 1'b1;
      req_valid = '0;
      fifo_full = 1'b0;
      fifo_almost_full = 1'b0;

      // Single requester, then all four, then a full/almost_full stall and resume.
      vecs[0]  = mk(4'b0100, L, L, 4'b0000, L, 8'h00, L, 16'd0);
      vecs[1]  = mk(4'b0100, L, L, 4'b0100, H, 8'hA5, H, 16'd0);
      vecs[2]  = mk(4'b0000, L, L, 4'b0100, L, 8'h00, H, 16'd1);
      vecs[3]  = mk(4'b0000, L, L, 4'b0000, L, 8'h00, L, 16'd1);
      vecs[4]  = mk(4'b1111, L, L, 4'b0000, L, 8'h00, L, 16'd1);
`ifdef FIFO_ARB_BURST_EN
      vecs[5]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd1);
      vecs[6]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd2);
      vecs[7]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd3);
      vecs[8]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd4);
      vecs[9]  = mk(4'b1111, L, L, 4'b0001, H, 8'h11, H, 16'd5);
`else
      vecs[5]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd1);
      vecs[6]  = mk(4'b1111, L, L, 4'b0001, H, 8'h11, H, 16'd2);
      vecs[7]  = mk(4'b1111, L, L, 4'b0010, H, 8'h22, H, 16'd3);
      vecs[8]  = mk(4'b1111, L, L, 4'b0100, H, 8'hA5, H, 16'd4);
      vecs[9]  = mk(4'b1111, L, L, 4'b1000, H, 8'h44, H, 16'd5);
`endif
      vecs[10] = mk(4'b1111, H, H, 4'b0000, L, 8'h00, H, 16'd6);
      vecs[11] = mk(4'b1111, L, H, 4'b0000, L, 8'h00, H, 16'd6);
      vecs[12] = mk(4'b1111, L, H, 4'b0000, L, 8'h00, H, 16'd6);
      vecs[13] = mk(4'b1111, L, L, 4'b0000, L, 8'h00, H, 16'd6);
      vecs[14] = mk(4'b1111, L, L, 4'b0001, H, 8'h11, H, 16'd6);
`ifdef FIFO_ARB_BURST_EN
      vecs[15] = mk(4'b1111, L, H, 4'b0001, H, 8'h11, H, 16'd7);
      vecs[16] = mk(4'b0000, L, L, 4'b0001, L, 8'h00, H, 16'd8);
      for (int i = 0; i < 12; i++) exp_order[i] = (i >= 4 && i < 8) ? 1 : 0;
`else
      vecs[15] = mk(4'b1111, L, H, 4'b0010, H, 8'h22, H, 16'd7);
      vecs[16] = mk(4'b0000, L, L, 4'b0100, L, 8'h00, H, 16'd8);
      for (int i = 0; i < 12; i++) exp_order[i] = i % 2;
`endif
      vecs[17] = mk(4'b0000, L, L, 4'b0000, L, 8'h00, L, 16'd8);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_outputs", outs(), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         req_valid        = vecs[i].valid;
         fifo_full        = vecs[i].full;
         fifo_almost_full = vecs[i].afull;
         #1;
         check($sformatf("vec%0d", i), outs(),
               {2'b00, vecs[i].ready, vecs[i].we, vecs[i].data, vecs[i].busy, vecs[i].cnt});
      end

      // Reset pulsed while a requester holds a grant with valid high.
      @(negedge clk);
      req_valid = 4'b1111;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_cycle_no_write", outs(), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_outputs", outs(), 32'h0);
      @(negedge clk);
      #1;
      check("post_rst_grant_req0", {22'd0, req_ready, fifo_write_enable, fifo_data_in},
            {22'd0, 4'b0001, 1'b1, 8'h11});

      // Two continuous requesters: order of accepted beats.
      do_reset();
      req_valid = 4'b0011;
      k = 0;
      for (int c = 0; c < 40 && k < 12; c++) begin
         @(negedge clk);
         #1;
         if (fifo_write_enable) begin
            check($sformatf("order_beat%0d", k), 32'(oh2idx(req_ready)), 32'(exp_order[k]));
            k++;
         end
      end
      if (k < 12) check("order_timeout", 32'(k), 32'd12);

      // Counter wrap: 65535 writes read 0xFFFF, two more read 0x0001.
      do_reset();
      req_valid = 4'b0001;
      writes = 0;
      seen_ffff = 1'b0;
      for (int c = 0; c < 70000; c++) begin
         @(negedge clk);
         #1;
         if (writes == 65535 && !seen_ffff) begin
            check("wr_count_ffff", 32'(wr_count), 32'h0000FFFF);
            seen_ffff = 1'b1;
         end
         if (writes == 65537) break;
         if (fifo_write_enable) writes++;
      end
      if (writes == 65537) check("wr_count_wrap", 32'(wr_count), 32'h00000001);
      else                 check("wrap_timeout", 32'(writes), 32'd65537);
      req_valid = '0;

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
